// File: rtl/hsi_mse_pkg.sv
`default_nettype none
// ============================================================================
// hsi_mse_pkg: shared types and default sizes for the HSI MSE datapath.
// Rev 1.0
// ============================================================================
package hsi_mse_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int BURST_LEN_DEF = 8;
  localparam int TIMEOUT_DEF   = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick: first set bit of req scanning upward from ptr, wrapping modulo N.
// Rev 1.0
// ============================================================================
module rr_pick
  import hsi_mse_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  always_comb begin
    int j;
    idx = '0;
    any = |req;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) idx = IDX_W'(j);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_scheduler.sv
`default_nettype none
// ============================================================================
// fifo_rr_scheduler: round-robin burst scheduler, NUM_REQ FIFOs -> one consumer.
// FIFO_RR_SCHED_TIMEOUT_EN adds a stall-timeout burst abort.  Rev 1.0
// ============================================================================
module fifo_rr_scheduler
  import hsi_mse_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_REQ-1:0]            fifo_rd_en,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_id,
  output logic                          out_last,
  output logic                          busy,
  output logic                          burst_abort
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(BURST_LEN - 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_id_q, out_id_d;
  logic             out_last_q, out_last_d;

  logic             w_pop;
  logic             w_pick_any;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_sel_next;
  logic [DATA_WIDTH-1:0] w_word [NUM_REQ];

`ifdef FIFO_RR_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               burst_abort_q, burst_abort_d;
`endif

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (~fifo_empty),
    .ptr (rr_ptr_q),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_word[g] = fifo_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_sel_next = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    word_cnt_d  = word_cnt_q;
    w_pop       = (state_q == GRANT) && !fifo_empty[sel_q] && out_ready;
    out_valid_d = w_pop;
    out_id_d    = sel_q;
    out_last_d  = w_pop && (word_cnt_q == c_last_cnt);
`ifdef FIFO_RR_SCHED_TIMEOUT_EN
    stall_d       = stall_q;
    burst_abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && w_pick_any) begin
          sel_d      = w_pick_idx;
          word_cnt_d = '0;
          state_d    = GRANT;
`ifdef FIFO_RR_SCHED_TIMEOUT_EN
          stall_d    = '0;
`endif
        end
      end
      GRANT: begin
        if (w_pop) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == c_last_cnt) begin
            state_d  = IDLE;
            rr_ptr_d = w_sel_next;
          end
`ifdef FIFO_RR_SCHED_TIMEOUT_EN
          stall_d = '0;
        end else if (fifo_empty[sel_q]) begin
          // Abort on the TIMEOUT-th consecutive empty cycle of the granted FIFO.
          if (stall_q == STALL_W'(TIMEOUT - 1)) begin
            stall_d       = '0;
            burst_abort_d = 1'b1;
            state_d       = IDLE;
            rr_ptr_d      = w_sel_next;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      word_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      word_cnt_q  <= word_cnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef FIFO_RR_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q       <= '0;
      burst_abort_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      burst_abort_q <= burst_abort_d;
    end
  end
  assign burst_abort = burst_abort_q;
`else
  assign burst_abort = 1'b0;
`endif

  assign fifo_rd_en = w_pop ? (NUM_REQ'(1) << sel_q) : '0;
  assign out_valid  = out_valid_q;
  assign out_id     = out_id_q;
  assign out_last   = out_last_q;
  // FIFO data lags rd_en by one cycle, so it lines up with the registered id.
  assign out_data   = out_valid_q ? w_word[out_id_q] : '0;
  assign busy       = (state_q == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_fifo_rr_scheduler: scoreboard bench with FIFO models and a queue-level
// round-robin reference.  Rev 1.0
// ============================================================================
module tb_fifo_rr_scheduler;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int BL = 8;

  logic            clk;
  logic            rst;
  logic            en;
  logic [NR-1:0]   fifo_empty = '1;
  logic [NR*DW-1:0] fifo_data;
  logic [NR-1:0]   fifo_rd_en;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_last;
  logic            busy;
  logic            burst_abort;

  fifo_rr_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .busy(busy), .burst_abort(burst_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] q    [NR][$];
  logic [DW-1:0] pend [NR][$];
  logic [DW-1:0] mq   [NR][$];
  logic [DW-1:0] data_r [NR];
  int            mptr = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            popcnt [NR];
  int            abort_cnt = 0;
  int            pc = 0;
  bit            gap = 0;

  assign fifo_data = {data_r[3], data_r[2], data_r[1], data_r[0]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Requester FIFO models with one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        q[i].delete();
        pend[i].delete();
        data_r[i] <= '0;
      end
      fifo_empty <= '1;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (fifo_rd_en[i] && q[i].size() > 0) data_r[i] <= q[i].pop_front();
        while (pend[i].size() > 0) q[i].push_back(pend[i].pop_front());
        fifo_empty[i] <= (q[i].size() == 0);
      end
    end
  end

  // Monitor: protocol checks and scoreboard compare on every presented word.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pc  = 0;
      gap = 0;
    end else begin
      if (gap) begin
        check("idle_gap", {busy, fifo_rd_en}, 0);
        gap = 0;
      end
      if (fifo_rd_en != 0) begin
        check("rd_en_legal", {$onehot(fifo_rd_en), out_ready, |(fifo_rd_en & fifo_empty)}, 3'b110);
        for (int i = 0; i < NR; i++) popcnt[i] += int'(fifo_rd_en[i]);
        pc++;
        if (pc == BL) begin
          gap = 1;
          pc  = 0;
        end
      end
      if (burst_abort) begin
        abort_cnt++;
        pc = 0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: actual id=%0d data=%0h last=%0b required none", out_id, out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {out_id, out_data, out_last}, {e.id, e.data, e.last});
        end
      end else begin
        check("idle_data_zero", {out_last, out_data}, 0);
      end
`ifndef FIFO_RR_SCHED_TIMEOUT_EN
      check("abort_tied_low", burst_abort, 0);
`endif
    end
  end

  task automatic load(input int r, input int n, input int base, input bit rnd);
    logic [DW-1:0] d;
    for (int w = 0; w < n; w++) begin
      d = rnd ? DW'($urandom) : DW'(base + w);
      pend[r].push_back(d);
      mq[r].push_back(d);
    end
  endtask

  // Reference: whole bursts from the first non-empty queue at/after the pointer.
  task automatic model_run();
    int  pick;
    bit  found;
    exp_t e;
    forever begin
      found = 0;
      pick  = 0;
      for (int k = 0; k < NR; k++) begin
        if (!found && mq[(mptr + k) % NR].size() > 0) begin
          found = 1;
          pick  = (mptr + k) % NR;
        end
      end
      if (!found) return;
      for (int w = 0; w < BL; w++) begin
        e.id   = 2'(pick);
        e.data = mq[pick].pop_front();
        e.last = (w == BL - 1);
        exp_q.push_back(e);
      end
      mptr = (pick + 1) % NR;
    end
  endtask

  task automatic wait_done(input string name, input bit rnd);
    bit done;
    done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (rnd) begin
        out_ready = ($urandom % 4) != 0;
        en        = ($urandom % 4) != 0;
      end
      done = (exp_q.size() == 0) && !busy && (&fifo_empty) && (pend[0].size() == 0) &&
             (pend[1].size() == 0) && (pend[2].size() == 0) && (pend[3].size() == 0);
    end
    out_ready = 1'b1;
    en        = 1'b1;
    check({name, "_drain"}, {done, exp_q.size()}, {1'b1, 32'd0});
  endtask

  int snap [NR];
  int npop;
  int gcyc;
  int abort_snap;
  bit stop;

  task automatic take_snap();
    for (int i = 0; i < NR; i++) snap[i] = popcnt[i];
  endtask

  initial begin
    for (int i = 0; i < NR; i++) popcnt[i] = 0;
    rst = 1'b0; en = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {out_valid, out_last, busy, burst_abort, fifo_rd_en, out_id, out_data}, 0);
    rst = 1'b0; en = 1'b1;

    // Single requester on FIFO 2.
    take_snap();
    load(2, 8, 0, 0);
    model_run();
    wait_done("single", 0);
    for (int i = 0; i < NR; i++) check("single_pops", popcnt[i] - snap[i], (i == 2) ? 8 : 0);

    // Pointer now 3: FIFO 3 must win over FIFO 1, then wrap.
    load(1, 8, 'h110, 0);
    load(3, 8, 'h130, 0);
    model_run();
    wait_done("ptr_wrap", 0);

    // Async reset on the 3rd pop of a burst.
    load(2, 8, 'h200, 0);
    model_run();
    npop = 0;
    for (int t = 0; t < 40 && npop < 3; t++) begin
      @(negedge clk);
      if (fifo_rd_en[2]) npop++;
    end
    check("rst_reach_pop3", npop, 3);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {out_valid, out_last, busy, burst_abort, fifo_rd_en, out_id, out_data}, 0);
    exp_q.delete();
    for (int r = 0; r < NR; r++) mq[r].delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    check("rst_hold_outputs", {out_valid, busy, fifo_rd_en}, 0);
    rst = 1'b0;
    load(0, 8, 'h400, 0);
    load(3, 8, 'h430, 0);
    model_run();
    wait_done("post_reset", 0);

    // All four FIFOs with two bursts each.
    take_snap();
    for (int r = 0; r < NR; r++) load(r, 16, 'h1000 * (r + 1), 0);
    model_run();
    wait_done("all_four", 0);
    for (int i = 0; i < NR; i++) check("all_four_pops", popcnt[i] - snap[i], 16);

    // out_ready alternating 0,1 from the first GRANT cycle.
    out_ready = 1'b0;
    load(0, 8, 'h500, 0);
    model_run();
    for (int t = 0; t < 20 && !busy; t++) @(negedge clk);
    check("toggle_start", busy, 1);
    gcyc = 0;
    stop = 0;
    for (int k = 0; k < 40 && !stop; k++) begin
      if (!busy) stop = 1;
      else begin
        gcyc++;
        out_ready = k[0];
        @(negedge clk);
      end
    end
    check("toggle_grant_cycles", gcyc, 16);
    wait_done("toggle", 0);

    // Stall: FIFO 1 holds only 5 words.
    take_snap();
    abort_snap = abort_cnt;
    for (int w = 0; w < 5; w++) pend[1].push_back(DW'('h300 + w));
`ifdef FIFO_RR_SCHED_TIMEOUT_EN
    for (int w = 0; w < 5; w++) exp_q.push_back('{2'd1, DW'('h300 + w), 1'b0});
`else
    for (int w = 0; w < 8; w++) exp_q.push_back('{2'd1, DW'('h300 + w), w == 7});
`endif
    mptr = 2;
    repeat (40) @(negedge clk);
    check("stall_pops", popcnt[1] - snap[1], 5);
`ifdef FIFO_RR_SCHED_TIMEOUT_EN
    check("abort_pulses", abort_cnt - abort_snap, 1);
    check("abort_idle", busy, 0);
    check("abort_no_more", exp_q.size(), 0);
`else
    check("stall_busy", busy, 1);
    check("stall_pending", exp_q.size(), 3);
    for (int w = 5; w < 8; w++) pend[1].push_back(DW'('h300 + w));
    wait_done("stall_resume", 0);
`endif

    // Randomized rounds with random en / out_ready.
    for (int rd = 0; rd < 12; rd++) begin
      for (int r = 0; r < NR; r++) load(r, BL * int'($urandom % 4), 0, 1);
      model_run();
      wait_done("random", 1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
